// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with a fully registered in_ready.
// out_data_q doubles as the head entry; skid_q holds the second word when FULL.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] NOP_WORD = 32'h0000_0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  // The encoding is the occupancy count, so occupancy never reads 3.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept_s;
  logic             emit_s;

  assign accept_s = in_valid & in_ready_q;
  assign emit_s   = out_valid_q & out_ready;

  // Next-state and next-output computation; in_data is only selected on an accept.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    skid_d     = skid_q;
    if (flush) begin
      state_d    = ST_EMPTY;
      out_data_d = NOP_WORD;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d    = ST_ONE;
            out_data_d = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          case ({accept_s, emit_s})
            2'b11: begin
              out_data_d = in_data;
            end
            2'b10: begin
              state_d = ST_FULL;
              skid_d  = in_data;
            end
            2'b01: begin
              state_d    = ST_EMPTY;
              out_data_d = NOP_WORD;
            end
            default: begin
              state_d = ST_ONE;
            end
          endcase
        end
        ST_FULL: begin
          if (emit_s) begin
            state_d    = ST_ONE;
            out_data_d = skid_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          out_data_d = NOP_WORD;
        end
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  // All state and registered outputs; in_ready stays low until the first edge out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= NOP_WORD;
      skid_q      <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a random soak,
// all compared against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic [1:0]  occupancy;

  int n_cmp;
  int n_bad;

  logic [31:0] mq[$];
  logic        m_ready;

  pipe_skid_reg #(.WIDTH(32), .NOP_WORD(NOP)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .flush    (flush),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, mq.size() > 0});
    check_val({tag, ".out_data"}, out_data, (mq.size() > 0) ? mq[0] : NOP);
    check_val({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, m_ready});
    check_val({tag, ".occupancy"}, {30'd0, occupancy}, mq.size());
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check after it.
  task automatic step(input string tag, input logic iv, input logic [31:0] id,
                      input logic ordy, input logic fl);
    bit acc;
    bit em;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clock);
    acc = iv && m_ready;
    em  = (mq.size() > 0) && ordy;
    if (fl) begin
      mq.delete();
    end else begin
      if (em) void'(mq.pop_front());
      if (acc) mq.push_back(id);
    end
    m_ready = (mq.size() < 2);
    #1;
    check_all(tag);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    m_ready   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_all("reset");
    end
    reset = 1'b1;
    step("startup", 1'b0, 32'd0, 1'b0, 1'b0);

    // Streaming with the consumer always ready.
    step("stream0", 1'b1, 32'h1111_1111, 1'b1, 1'b0);
    step("stream1", 1'b1, 32'h2222_2222, 1'b1, 1'b0);
    step("stream2", 1'b1, 32'h3333_3333, 1'b1, 1'b0);
    step("stream3", 1'b0, 32'd0, 1'b1, 1'b0);

    // Back-pressure fill, stall, then drain.
    step("bp_fill0", 1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    step("bp_fill1", 1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
    step("bp_stall0", 1'b1, 32'hAAAA_0003, 1'b0, 1'b0);
    step("bp_stall1", 1'b0, 32'd0, 1'b0, 1'b0);
    check_val("bp_head", out_data, 32'hAAAA_0001);
    step("bp_drain0", 1'b0, 32'd0, 1'b1, 1'b0);
    check_val("bp_second", out_data, 32'hAAAA_0002);
    check_val("bp_ready_after_emit", {31'd0, in_ready}, 32'd1);
    step("bp_drain1", 1'b0, 32'd0, 1'b1, 1'b0);

    // Flush while FULL together with an incoming word.
    step("fl_fill0", 1'b1, 32'hBEEF_0001, 1'b0, 1'b0);
    step("fl_fill1", 1'b1, 32'hBEEF_0002, 1'b0, 1'b0);
    step("fl_flush", 1'b1, 32'hDEAD_0000, 1'b0, 1'b1);
    check_val("fl_no_dead", {31'd0, out_data == 32'hDEAD_0000}, 32'd0);
    step("fl_after", 1'b0, 32'd0, 1'b1, 1'b0);
    check_val("fl_no_dead2", {31'd0, out_data == 32'hDEAD_0000}, 32'd0);

    // Async reset between edges while FULL.
    step("ar_fill0", 1'b1, 32'hC0DE_0001, 1'b0, 1'b0);
    step("ar_fill1", 1'b1, 32'hC0DE_0002, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    mq.delete();
    m_ready = 1'b0;
    #1;
    check_all("ar_async");
    @(posedge clock);
    #1;
    check_all("ar_held");
    reset = 1'b1;
    step("ar_release", 1'b0, 32'd0, 1'b1, 1'b0);
    step("ar_idle", 1'b0, 32'd0, 1'b1, 1'b0);

    // Random soak; in_data is junk whenever in_valid is low.
    for (int i = 0; i < 10000; i++) begin
      logic        iv;
      logic        ordy;
      logic        fl;
      logic [31:0] d;
      iv   = ($urandom_range(99) < 60);
      ordy = ($urandom_range(99) < 55);
      fl   = ($urandom_range(199) == 0);
      d    = iv ? $urandom : 32'hFFFF_FFFF ^ $urandom;
      step("soak", iv, d, ordy, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- 2-entry skid-buffered pipeline register, WIDTH bits wide.
- Sits directly downstream of the 32-bit word latch and consumes its q output as in_data.
- Provides a valid/ready handshake to the next stage.
- in_ready is fully registered, so there is no combinational path from out_ready to in_ready; back-pressure cannot form long timing paths through the datapath.

Parameters:
WIDTH, 32, data word width in bits
NOP_WORD, 32'h0000_0000, value driven on out_data whenever the buffer is empty, after reset, and after flush

Ports:
clock  input  1  sole clock, rising-edge active
reset  input  1  asynchronous, active-low reset; low clears all state immediately
in_data  input  WIDTH  upstream word (the latch q output)
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle (registered)
out_data  output  WIDTH  head-of-buffer word (registered)
out_valid  output  1  out_data is valid (registered)
out_ready  input  1  downstream accepts out_data this cycle
flush  input  1  synchronous discard of all buffered words
occupancy  output  2  number of held words, 0..2

Behaviour:
- Transfers:
  - Accept = in_valid & in_ready at a rising edge.
  - Emit = out_valid & out_ready at a rising edge.
- States:
  - EMPTY (occupancy 0)
  - ONE (1; the word is in the head register)
  - FULL (2; head plus skid register)
- Registered outputs per state:
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - out_data = head entry, or NOP_WORD in EMPTY.
- Transitions, when flush = 0:
  - EMPTY: accept -> ONE, head <= in_data; otherwise stay.
  - ONE, accept & emit: stay ONE, head <= in_data.
  - ONE, accept only: -> FULL, skid <= in_data.
  - ONE, emit only: -> EMPTY, out_data <= NOP_WORD.
  - ONE, neither: hold.
  - FULL, emit: -> ONE, head <= skid. Accept is impossible because in_ready = 0.
  - FULL, no emit: hold everything.
- Latency:
  - Word accepted at edge k appears on out_data with out_valid = 1 after edge k, when the buffer was EMPTY, or when it was ONE with a simultaneous emit.
  - Otherwise the word waits behind older words. Strict FIFO order is required; no word may be duplicated or dropped.
- Data stability: while out_valid = 1 and out_ready = 0, out_data and out_valid must not change (except on flush or reset).
- Flush, synchronous and highest priority:
  - At an edge with flush = 1: state <= EMPTY, out_valid <= 0, out_data <= NOP_WORD, in_ready <= 1, occupancy <= 0.
  - An accept in the same cycle is discarded.
  - An emit in the same cycle counts as completed for downstream.
  - Skid contents are don't-care after a flush.
- Reset:
  - While reset = 0, asynchronously: state EMPTY, out_valid 0, out_data NOP_WORD, occupancy 0, in_ready 0.
  - in_ready rises to 1 at the first rising edge with reset = 1.
  - Reset asserted mid-transfer abandons all held words, with no partial update.
- Input qualification: in_data is sampled only on an accept. X on in_data while in_valid = 0 must not propagate to out_data.
- occupancy always equals the state encoding: 0/1/2, never 3.

Test Plan:
- Reset and startup: hold reset = 0 for 3 cycles, release. Required: out_valid = 0, out_data = 0, occupancy = 0 and in_ready = 0 during reset; in_ready = 1 after the first edge.
- Streaming: out_ready = 1, send 0x11111111, 0x22222222, 0x33333333 on consecutive cycles. Required: each word appears on out_data one cycle after its accept, in order, occupancy stays 1, in_ready stays 1.
- Back-pressure fill:
  - Setup: out_ready = 0; send 0xAAAA0001, then 0xAAAA0002.
  - Required while stalled: occupancy = 2 and in_ready = 0 the following cycle; out_data holds 0xAAAA0001 and is stable.
  - Then raise out_ready. Required: 0xAAAA0001 then 0xAAAA0002 emitted; in_ready = 1 one cycle after the first emit.
- Flush:
  - Setup: in FULL (0xBEEF0001, 0xBEEF0002), assert flush together with in_valid = 1 carrying 0xDEAD0000.
  - Required next cycle: occupancy = 0, out_valid = 0, out_data = NOP_WORD, in_ready = 1.
  - 0xDEAD0000 never appears on out_data.
- Async reset mid-operation: with occupancy = 2, pull reset low between clock edges. Required: out_valid drops to 0 and occupancy to 0 without waiting for an edge; no held word is ever emitted afterwards.
- Random soak: 10,000 cycles of random in_valid, out_ready and rare flush, checked against a reference queue. Required: no loss, duplication or reordering between flushes, and the out_data stability rule is never violated.
